// File: rtl/r16_fft_sched.sv
// Radix-16 in-place FFT stage sequencer: walks STAGES passes over the 2-bank point
// memory, one read per cycle, with a fixed write-back drain gap between passes.
module r16_fft_sched #(
  parameter int A_WIDTH   = 11,
  parameter int STAGES    = 3,
  parameter int DRAIN_CYC = 48
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               hold,
  output logic               busy,
  output logic               done,
  output logic               rd_valid,
  output logic               BN_out,
  output logic [A_WIDTH-1:0] MA_out,
  output logic [1:0]         stage_out
);

  localparam int JW = A_WIDTH + 1;
  localparam int DW = (DRAIN_CYC > 0) ? $clog2(DRAIN_CYC + 1) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [JW-1:0] J_LAST      = {JW{1'b1}};
  localparam logic [DW-1:0] DRAIN_LAST  = DW'(DRAIN_CYC);
  localparam logic [1:0]    STAGE_LAST  = 2'(STAGES - 1);

  // Exchange base-16 digit 0 with digit s of the point counter.
  function automatic logic [JW-1:0] swap_digit(input logic [JW-1:0] j, input logic [1:0] s);
    logic [JW-1:0] idx;
    idx = j;
    for (int d = 1; d < STAGES; d++) begin
      if (s == 2'(d)) begin
        idx[3:0]       = j[4*d +: 4];
        idx[4*d +: 4]  = j[3:0];
      end
    end
    return idx;
  endfunction

  function automatic logic bank_parity(input logic [JW-1:0] v);
    return ^v;
  endfunction

  logic [1:0]         state_q, state_d;
  logic [JW-1:0]      j_q, j_d;
  logic [DW-1:0]      drain_q, drain_d;
  logic [1:0]         stage_q, stage_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               rd_valid_q, rd_valid_d;
  logic               bn_q, bn_d;
  logic [A_WIDTH-1:0] ma_q, ma_d;
  logic [JW-1:0]      run_idx_s;

  // Permuted point index for the read issued from the current counter value.
  always_comb begin
    run_idx_s = swap_digit(j_q, stage_q);
  end

  // Next-state and next-output logic; outputs are computed one cycle ahead so the
  // register stage presents them in the issue cycle. Entering a pass issues j=0
  // immediately (idx 0 -> bank 0, address 0 in every pass).
  always_comb begin
    state_d    = state_q;
    j_d        = j_q;
    drain_d    = drain_q;
    stage_d    = stage_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    rd_valid_d = 1'b0;
    bn_d       = bn_q;
    ma_d       = ma_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d    = S_RUN;
          stage_d    = 2'd0;
          busy_d     = 1'b1;
          rd_valid_d = 1'b1;
          bn_d       = 1'b0;
          ma_d       = {A_WIDTH{1'b0}};
          j_d        = JW'(1);
        end else begin
          busy_d = 1'b0;
        end
      end
      S_RUN: begin
        if (hold) begin
          rd_valid_d = 1'b0;
        end else begin
          rd_valid_d = 1'b1;
          bn_d       = bank_parity(run_idx_s);
          ma_d       = run_idx_s[JW-1:1];
          j_d        = j_q + JW'(1);
          if (j_q == J_LAST) begin
            state_d = S_DRAIN;
            drain_d = {DW{1'b0}};
          end else begin
            state_d = S_RUN;
          end
        end
      end
      S_DRAIN: begin
        if (drain_q == DRAIN_LAST) begin
          drain_d = {DW{1'b0}};
          if (stage_q == STAGE_LAST) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            stage_d = 2'd0;
          end else begin
            state_d    = S_RUN;
            stage_d    = stage_q + 2'd1;
            rd_valid_d = 1'b1;
            bn_d       = 1'b0;
            ma_d       = {A_WIDTH{1'b0}};
            j_d        = JW'(1);
          end
        end else begin
          drain_d = drain_q + DW'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        stage_d = 2'd0;
        j_d     = {JW{1'b0}};
        drain_d = {DW{1'b0}};
      end
    endcase
  end

  // State, counters and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      j_q        <= {JW{1'b0}};
      drain_q    <= {DW{1'b0}};
      stage_q    <= 2'd0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      rd_valid_q <= 1'b0;
      bn_q       <= 1'b0;
      ma_q       <= {A_WIDTH{1'b0}};
    end else begin
      state_q    <= state_d;
      j_q        <= j_d;
      drain_q    <= drain_d;
      stage_q    <= stage_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      rd_valid_q <= rd_valid_d;
      bn_q       <= bn_d;
      ma_q       <= ma_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign rd_valid  = rd_valid_q;
  assign BN_out    = bn_q;
  assign MA_out    = ma_q;
  assign stage_out = stage_q;

endmodule

// File: tb/tb_r16_fft_sched.sv
// Directed bench for r16_fft_sched: full transforms, hold stalls, drain gap,
// completion timing and abort/restart, sampled on the falling edge.
module tb_r16_fft_sched;

  localparam int AW   = 11;
  localparam int ST   = 3;
  localparam int DC   = 48;
  localparam int NPTS = 1 << (AW + 1);

  logic          clk = 1'b0;
  logic          rst, start, hold;
  logic          busy, done, rd_valid, bn;
  logic [AW-1:0] ma;
  logic [1:0]    stage_o;

  int n_chk = 0;
  int n_err = 0;

  r16_fft_sched #(.A_WIDTH(AW), .STAGES(ST), .DRAIN_CYC(DC)) dut (
    .clk(clk), .rst(rst), .start(start), .hold(hold),
    .busy(busy), .done(done), .rd_valid(rd_valid),
    .BN_out(bn), .MA_out(ma), .stage_out(stage_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [AW:0] ref_idx(input int n, input int s);
    logic [AW:0] j, idx;
    j   = n[AW:0];
    idx = j;
    if (s > 0) begin
      idx[3:0]      = j[4*s +: 4];
      idx[4*s +: 4] = j[3:0];
    end
    return idx;
  endfunction

  // Hand values for j=0..3 of pass 0 and j=1 of each pass.
  logic        exp_bn0 [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
  logic [10:0] exp_ma0 [4] = '{11'd0, 11'd0, 11'd1, 11'd1};
  logic [10:0] exp_ma1 [3] = '{11'h000, 11'h008, 11'h080};

  int            cur_pass, issue_cnt, gap, gap_bad, seq_err, dup_err, extra_err;
  int            done_cnt, done_cyc, busy_at_done, post_cnt, post_bad;
  int            hold_used, hold_cycles, frozen_err, abort_hit;
  int            j1_bn [3];
  int            j1_ma [3];
  logic          last_bn;
  logic [AW-1:0] last_ma;
  logic [NPTS-1:0] seen;

  task automatic check_idle(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_valid"}, rd_valid, 0);
    check({tag, "_bn"}, bn, 0);
    check({tag, "_ma"}, ma, 0);
    check({tag, "_stage"}, stage_o, 0);
  endtask

  task automatic start_xfer();
    @(negedge clk);
    start = 1'b1;
    check("t_busy", busy, 0);
    check("t_valid", rd_valid, 0);
    @(negedge clk);
    start = 1'b0;
  endtask

  // Observes one transform from its first issue cycle (cyc 0) and drives hold/start/rst.
  task automatic monitor(input bit do_hold, input bit do_abort);
    int cyc;
    int n;
    bit fin;
    logic [AW:0] idx;
    logic [AW:0] rec;
    cur_pass = 0; issue_cnt = 0; gap = 0; gap_bad = 0; seq_err = 0; dup_err = 0;
    extra_err = 0; done_cnt = 0; done_cyc = -1; busy_at_done = -1; post_cnt = 0;
    post_bad = 0; hold_used = 0; hold_cycles = 0; frozen_err = 0; abort_hit = 0;
    for (int p = 0; p < 3; p++) begin j1_bn[p] = -1; j1_ma[p] = -1; end
    seen = '0; last_bn = 1'b0; last_ma = '0;
    cyc = 0; fin = 1'b0;
    while (!fin && cyc < 13000) begin
      if (rd_valid === 1'b1) begin
        if (cur_pass >= ST) begin
          extra_err++;
        end else begin
          n = issue_cnt;
          if (cur_pass > 0 && n == 0) begin
            check($sformatf("gap_len_p%0d", cur_pass), gap, DC);
            check($sformatf("gap_state_p%0d", cur_pass), gap_bad, 0);
          end
          idx = ref_idx(n, cur_pass);
          if (bn !== ^idx || ma !== idx[AW:1] || stage_o !== 2'(cur_pass)) seq_err++;
          rec = {ma, bn ^ (^ma)};
          if (seen[rec]) dup_err++;
          seen[rec] = 1'b1;
          if (cur_pass == 0 && n < 4) begin
            check($sformatf("first_bn_j%0d", n), bn, exp_bn0[n]);
            check($sformatf("first_ma_j%0d", n), ma, exp_ma0[n]);
          end
          if (n == 1) begin j1_bn[cur_pass] = bn; j1_ma[cur_pass] = ma; end
          last_bn = bn; last_ma = ma;
          issue_cnt++;
          if (issue_cnt == NPTS) begin
            check($sformatf("pass_seq_p%0d", cur_pass), seq_err, 0);
            check($sformatf("pass_dup_p%0d", cur_pass), dup_err, 0);
            check($sformatf("pass_cover_p%0d", cur_pass), &seen, 1);
            seq_err = 0; dup_err = 0; seen = '0;
            cur_pass++; issue_cnt = 0; gap = 0; gap_bad = 0;
          end
        end
      end else if (done === 1'b1) begin
        done_cnt++; done_cyc = cyc; busy_at_done = busy;
      end else if (done_cnt > 0) begin
        post_cnt++;
        if (busy !== 1'b0 || stage_o !== 2'd0) post_bad++;
      end else if (cur_pass > 0 && issue_cnt == 0) begin
        gap++;
        if (busy !== 1'b1 || stage_o !== 2'(cur_pass - 1)) gap_bad++;
      end else if (cur_pass == 1 && issue_cnt == 100) begin
        hold_cycles++;
        if (bn !== last_bn || ma !== last_ma || busy !== 1'b1) frozen_err++;
      end
      hold  = 1'b0;
      start = (done === 1'b1);
      if (do_hold && cur_pass == 1 && issue_cnt == 100 && hold_used < 5) begin
        hold = 1'b1; hold_used++;
      end
      if (do_hold && cur_pass == 1 && issue_cnt == 0 && gap >= 5 && gap < 15) hold = 1'b1;
      if (do_abort && cur_pass == ST && gap == 10) begin
        rst = 1'b1; fin = 1'b1; abort_hit = 1;
      end
      if (post_cnt >= 6) fin = 1'b1;
      @(negedge clk);
      cyc++;
    end
    hold  = 1'b0;
    start = 1'b0;
  endtask

  task automatic check_complete(input int exp_done);
    check("done_count", done_cnt, 1);
    check("done_cycle", done_cyc, exp_done);
    check("busy_at_done", busy_at_done, 0);
    check("final_gap", gap, DC);
    check("post_done_idle", post_bad, 0);
    check("post_done_cycles", post_cnt, 6);
    check("extra_issue", extra_err, 0);
    for (int p = 0; p < 3; p++) begin
      check($sformatf("j1_bn_p%0d", p), j1_bn[p], 1);
      check($sformatf("j1_ma_p%0d", p), j1_ma[p], exp_ma1[p]);
    end
  endtask

  initial begin
    int bad;
    rst = 1'b1; start = 1'b0; hold = 1'b0;
    repeat (3) @(negedge clk);
    check_idle("reset");
    rst = 1'b0;

    // Plain transform, start pulse in the done cycle must be ignored.
    start_xfer();
    monitor(1'b0, 1'b0);
    check_complete(12432);

    // Hold in pass-0 drain (no effect) and 5 cycles at pass-1 j=100.
    start_xfer();
    monitor(1'b1, 1'b0);
    check_complete(12437);
    check("hold_cycles", hold_cycles, 5);
    check("hold_frozen", frozen_err, 0);

    // Reset during pass-2 drain, then restart from scratch.
    start_xfer();
    monitor(1'b0, 1'b1);
    check("abort_reached", abort_hit, 1);
    check("abort_no_done", done_cnt, 0);
    check_idle("abort");
    rst = 1'b0;
    bad = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (rd_valid !== 1'b0 || done !== 1'b0 || busy !== 1'b0) bad++;
    end
    check("abort_quiet", bad, 0);
    start_xfer();
    monitor(1'b0, 1'b0);
    check_complete(12432);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
